// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;
    localparam int unsigned INST_W     = 32;

    localparam logic [INST_W-1:0]     NOP_INST         = 32'h0000_0013;
    localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INST_W-1:0]     inst;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; head is read straight from storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  fetch_entry_t               wdata_i,
    output fetch_entry_t               rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and occupancy tracking; flush empties the queue in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage needs no reset; only occupied slots are ever presented.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Writers must respect the credit scheme: never push into a full queue without a pop.
    overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited word fetches and buffers
// returned instructions for decode; redirects flush and drop stale responses.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN       = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEFAULT_RESET_PC),
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [31:0]     dec_inst,
    output logic [XLEN-1:0] dec_pc
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e    state_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;
    logic [CW-1:0]   drop_cnt_q;
    logic [CW-1:0]   drop_cnt_d;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   dec_count;
    logic            req_fire;
    logic            dec_push;
    logic            dec_pop;
    logic            dec_empty;
    logic            dec_full;
    logic            pcq_full;
    logic            pcq_empty;
    fetch_entry_t    pcq_wdata;
    fetch_entry_t    pcq_head;
    fetch_entry_t    dec_wdata;
    fetch_entry_t    dec_head;
    logic            status_unused;

    // Issue only while running and while in-flight plus buffered words leave room.
    assign imem_req_valid = (state_q == RUN)
                         && ((32'(outstanding) + 32'(dec_count)) < FIFO_DEPTH)
                         && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is kept only when no stale responses remain and no redirect is in progress.
    assign dec_push  = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);
    assign dec_pop   = dec_valid && dec_ready;
    assign pcq_wdata = '{inst: NOP_INST, pc: FETCH_XLEN'(fetch_pc_q)};
    assign dec_wdata = '{inst: imem_rsp_data, pc: pcq_head.pc};

    assign dec_valid = !dec_empty;
    assign dec_inst  = dec_empty ? NOP_INST : dec_head.inst;
    assign dec_pc    = dec_empty ? '0 : XLEN'(dec_head.pc);

    assign status_unused = ^{pcq_head.inst, pcq_full, pcq_empty, dec_full};

    // Next fetch address and number of stale responses still to discard.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            drop_cnt_d = outstanding - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    // Fetch FSM with PC and drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
            unique case (state_q)
                IDLE:    state_q <= RUN;
                RUN:     if (redirect_valid && (drop_cnt_d != '0)) state_q <= FLUSH;
                FLUSH:   if (drop_cnt_d == '0) state_q <= RUN;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Addresses of accepted requests, consumed in order as responses return.
    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pc_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (req_fire),
        .pop_i   (imem_rsp_valid),
        .flush_i (1'b0),
        .wdata_i (pcq_wdata),
        .rdata_o (pcq_head),
        .count_o (outstanding),
        .full_o  (pcq_full),
        .empty_o (pcq_empty)
    );

    // Decode buffer; its head drives the decode interface.
    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_dec_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (dec_push),
        .pop_i   (dec_pop),
        .flush_i (redirect_valid),
        .wdata_i (dec_wdata),
        .rdata_o (dec_head),
        .count_o (dec_count),
        .full_o  (dec_full),
        .empty_o (dec_empty)
    );

endmodule
